// File: rtl/nibble_lock_if.sv
// -----------------------------------------------------------------------------
// nibble_lock_if
// Groups the serial-entry, control and comparator signals of the code lock.
//   master modport : the user/comparator side that drives serial bits,
//                    relock/load_key pulses and the comparator eq result, and
//                    observes the code, key and status outputs.
//   slave modport  : nibble_lock_fsm itself.
// Signals:
//   ser_in, ser_valid   serial code bit (MSB first) and its qualifier
//   relock, load_key    single-cycle control pulses used in OPEN
//   eq                  comparator output, 1 when a == b
//   a, b                entered code and stored key, to the comparator
//   unlocked, fail, locked_out, busy, fail_cnt   registered status
// -----------------------------------------------------------------------------
interface nibble_lock_if;
  logic       ser_in;
  logic       ser_valid;
  logic       relock;
  logic       load_key;
  logic       eq;
  logic [3:0] a;
  logic [3:0] b;
  logic       unlocked;
  logic       fail;
  logic       locked_out;
  logic       busy;
  logic [2:0] fail_cnt;

  modport master (
    output ser_in, ser_valid, relock, load_key, eq,
    input  a, b, unlocked, fail, locked_out, busy, fail_cnt
  );

  modport slave (
    input  ser_in, ser_valid, relock, load_key, eq,
    output a, b, unlocked, fail, locked_out, busy, fail_cnt
  );
endinterface

// File: rtl/nibble_lock_fsm.sv
// -----------------------------------------------------------------------------
// nibble_lock_fsm
// Serial-entry code-lock controller wrapped around an external 4-bit equality
// comparator. A nibble is shifted in MSB first, presented on a together with
// the stored key on b, and the comparator's eq is sampled one cycle later.
// States: IDLE, SHIFT, CHECK, OPEN and (optionally) LOCKOUT.
//
// Optional feature macro: NIBBLE_LOCK_LOCKOUT_EN
//   defined   : MAX_TRIES consecutive wrong codes enter LOCKOUT for LOCK_CYCLES
//   undefined : no LOCKOUT state/timer, locked_out tied low, every wrong code
//               returns to IDLE with a fail pulse
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   nibble_lock_if.slave (serial input, control pulses, eq in;
//         a, b, unlocked, fail, locked_out, busy, fail_cnt out)
// Parameters: MAX_TRIES (1..7), LOCK_CYCLES (1..255), KEY_RESET.
// -----------------------------------------------------------------------------
module nibble_lock_fsm #(
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter logic [3:0]  KEY_RESET   = 4'b1010
) (
  input  logic         clk,
  input  logic         rst,
  nibble_lock_if.slave bus
);

  // Elaboration-time range checks on the configuration.
  if (MAX_TRIES < 1 || MAX_TRIES > 7) begin : g_bad_max_tries
    $error("nibble_lock_fsm: MAX_TRIES must be 1..7");
  end
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 255) begin : g_bad_lock_cycles
    $error("nibble_lock_fsm: LOCK_CYCLES must be 1..255");
  end

`ifdef NIBBLE_LOCK_LOCKOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CHECK, S_OPEN, S_LOCKOUT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CHECK, S_OPEN} state_t;
`endif

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] fail_cnt_q, fail_cnt_d;
  logic       load_flag_q, load_flag_d;
  logic       unlocked_q, unlocked_d;
  logic       fail_q, fail_d;
  logic       locked_out_q, locked_out_d;
  logic       busy_q, busy_d;
  logic [2:0] fail_cnt_inc;
`ifdef NIBBLE_LOCK_LOCKOUT_EN
  logic [7:0] timer_q, timer_d;
`endif

  // Failure count saturates at 7 rather than wrapping.
  assign fail_cnt_inc = (fail_cnt_q == 3'd7) ? 3'd7 : fail_cnt_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    bit_cnt_d   = bit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    load_flag_d = load_flag_q;
    fail_d      = 1'b0;
`ifdef NIBBLE_LOCK_LOCKOUT_EN
    timer_d     = timer_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.ser_valid) begin
          a_d       = {a_q[2:0], bus.ser_in};
          bit_cnt_d = 3'd1;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // After the 4th bit, a is held for one full cycle so the comparator
        // settles before CHECK samples eq.
        if (bit_cnt_q == 3'd4) begin
          state_d = S_CHECK;
        end else if (bus.ser_valid) begin
          a_d       = {a_q[2:0], bus.ser_in};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end

      S_CHECK: begin
        bit_cnt_d = 3'd0;
        if (load_flag_q) begin
          b_d         = a_q;
          load_flag_d = 1'b0;
          state_d     = S_OPEN;
        end else if (bus.eq) begin
          fail_cnt_d = 3'd0;
          state_d    = S_OPEN;
        end else begin
          fail_d     = 1'b1;
          fail_cnt_d = fail_cnt_inc;
          state_d    = S_IDLE;
`ifdef NIBBLE_LOCK_LOCKOUT_EN
          if (fail_cnt_inc == 3'(MAX_TRIES)) begin
            state_d = S_LOCKOUT;
            timer_d = 8'(LOCK_CYCLES);
          end
`endif
        end
      end

      S_OPEN: begin
        // relock has priority over load_key.
        if (bus.relock) begin
          state_d = S_IDLE;
        end else if (bus.load_key) begin
          state_d     = S_SHIFT;
          load_flag_d = 1'b1;
          bit_cnt_d   = 3'd0;
        end
      end

`ifdef NIBBLE_LOCK_LOCKOUT_EN
      S_LOCKOUT: begin
        timer_d = timer_q - 8'd1;
        if (timer_q <= 8'd1) begin
          state_d    = S_IDLE;
          fail_cnt_d = 3'd0;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered versions of the next-state decode.
    // During a key load the lock stays open until that CHECK completes.
    unlocked_d = (state_d == S_OPEN) || load_flag_d;
    busy_d     = (state_d == S_SHIFT) || (state_d == S_CHECK);
`ifdef NIBBLE_LOCK_LOCKOUT_EN
    busy_d       = busy_d || (state_d == S_LOCKOUT);
    locked_out_d = (state_d == S_LOCKOUT);
`else
    locked_out_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= 4'd0;
      b_q          <= KEY_RESET;
      bit_cnt_q    <= 3'd0;
      fail_cnt_q   <= 3'd0;
      load_flag_q  <= 1'b0;
      unlocked_q   <= 1'b0;
      fail_q       <= 1'b0;
      locked_out_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      bit_cnt_q    <= bit_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      load_flag_q  <= load_flag_d;
      unlocked_q   <= unlocked_d;
      fail_q       <= fail_d;
      locked_out_q <= locked_out_d;
      busy_q       <= busy_d;
    end
  end

`ifdef NIBBLE_LOCK_LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= 8'd0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.fail       = fail_q;
  assign bus.locked_out = locked_out_q;
  assign bus.busy       = busy_q;
  assign bus.fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_nibble_lock_fsm.sv
// -----------------------------------------------------------------------------
// tb_nibble_lock_fsm
// Self-checking bench for nibble_lock_fsm. A transaction-level model tracks
// the key, open/loading status and failure count; the comparator is modelled
// as a plain equality on the DUT's a/b outputs.
// -----------------------------------------------------------------------------
module tb_nibble_lock_fsm;

  localparam int         MAX_TRIES   = 3;
  localparam int         LOCK_CYCLES = 16;
  localparam logic [3:0] KEY_RESET   = 4'b1010;
`ifdef NIBBLE_LOCK_LOCKOUT_EN
  localparam bit LOCKOUT_EN = 1'b1;
`else
  localparam bit LOCKOUT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  nibble_lock_if bus ();

  // Behavioural 4-bit equality comparator.
  assign bus.eq = (bus.a == bus.b);

  nibble_lock_fsm #(
    .MAX_TRIES  (MAX_TRIES),
    .LOCK_CYCLES(LOCK_CYCLES),
    .KEY_RESET  (KEY_RESET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Transaction-level model.
  logic [3:0] m_key;
  logic [3:0] m_a;
  logic       m_open;
  logic       m_loading;
  int         m_fc;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_key     = KEY_RESET;
    m_a       = 4'd0;
    m_open    = 1'b0;
    m_loading = 1'b0;
    m_fc      = 0;
  endtask

  task automatic send_bit(input logic bit_val);
    bus.ser_valid = 1'b1;
    bus.ser_in    = bit_val;
    tick();
    bus.ser_valid = 1'b0;
    bus.ser_in    = 1'($urandom);
  endtask

  // Enter one 4-bit code with random gaps and check the whole outcome.
  task automatic enter_code(input logic [3:0] code, input int max_gap);
    logic was_loading;
    logic lock;
    logic exp_fail;
    int   gap;
    int   cyc;
    for (int i = 3; i >= 0; i--) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < gap; k++) begin
        bus.ser_in = 1'($urandom);
        tick();
      end
      send_bit(code[i]);
    end
    m_a = code;
    check("a_after_bit4", bus.a, m_a);
    check("busy_shift", bus.busy, 1);

    was_loading = m_loading;
    lock        = 1'b0;
    exp_fail    = 1'b0;
    if (m_loading) begin
      m_key     = code;
      m_loading = 1'b0;
      m_open    = 1'b1;
    end else if (code == m_key) begin
      m_fc   = 0;
      m_open = 1'b1;
    end else begin
      exp_fail = 1'b1;
      if (m_fc < 7) m_fc++;
      lock = LOCKOUT_EN && (m_fc == MAX_TRIES);
    end

    // CHECK cycle: nothing resolved yet; random bits here must be ignored.
    bus.ser_valid = 1'($urandom);
    tick();
    bus.ser_valid = 1'b0;
    check("chk_unlocked", bus.unlocked, was_loading);
    check("chk_fail", bus.fail, 0);
    check("chk_busy", bus.busy, 1);

    // Outcome visible two cycles after the last bit.
    tick();
    check("res_unlocked", bus.unlocked, m_open);
    check("res_fail", bus.fail, exp_fail);
    check("res_fail_cnt", bus.fail_cnt, 8'(m_fc));
    check("res_b", bus.b, m_key);
    check("res_locked_out", bus.locked_out, lock);
    check("res_busy", bus.busy, lock);
    check("res_a_held", bus.a, m_a);
    $display("txn code=%b key=%b open=%0d fail=%0d fail_cnt=%0d lock=%0d",
             code, m_key, m_open, exp_fail, m_fc, lock);

    if (lock) begin
      cyc = 0;
      while (bus.locked_out === 1'b1 && cyc < LOCK_CYCLES + 20) begin
        cyc++;
        bus.ser_valid = 1'($urandom);
        bus.ser_in    = 1'($urandom);
        bus.relock    = 1'($urandom);
        bus.load_key  = 1'($urandom);
        tick();
      end
      bus.ser_valid = 1'b0;
      bus.relock    = 1'b0;
      bus.load_key  = 1'b0;
      m_fc = 0;
      check("lockout_len", 8'(cyc), 8'(LOCK_CYCLES));
      check("post_lock_fail_cnt", bus.fail_cnt, 0);
      check("post_lock_busy", bus.busy, 0);
      check("post_lock_a", bus.a, m_a);
      check("post_lock_unlocked", bus.unlocked, 0);
      $display("txn lockout lasted %0d cycles", cyc);
    end else begin
      tick();
      check("fail_pulse_end", bus.fail, 0);
    end
  endtask

  task automatic do_relock(input logic with_load);
    bus.relock   = 1'b1;
    bus.load_key = with_load;
    tick();
    bus.relock   = 1'b0;
    bus.load_key = 1'b0;
    m_open = 1'b0;
    check("relock_unlocked", bus.unlocked, 0);
    check("relock_busy", bus.busy, 0);
    check("relock_b", bus.b, m_key);
    $display("txn relock load_key=%0d key=%b", with_load, m_key);
  endtask

  task automatic do_load(input logic [3:0] new_key);
    bus.load_key = 1'b1;
    tick();
    bus.load_key = 1'b0;
    m_loading = 1'b1;
    check("load_unlocked", bus.unlocked, 1);
    check("load_busy", bus.busy, 1);
    $display("txn load_key start");
    enter_code(new_key, 2);
  endtask

  task automatic open_idle_cycle();
    bus.ser_valid = 1'b1;
    bus.ser_in    = 1'($urandom);
    tick();
    bus.ser_valid = 1'b0;
    check("open_a_stable", bus.a, m_a);
    check("open_unlocked", bus.unlocked, 1);
    $display("txn open idle cycle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] code;
    int         op;

    rst           = 1'b1;
    bus.ser_in    = 1'b0;
    bus.ser_valid = 1'b0;
    bus.relock    = 1'b0;
    bus.load_key  = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst_a", bus.a, 0);
    check("rst_b", bus.b, KEY_RESET);
    check("rst_unlocked", bus.unlocked, 0);
    check("rst_fail", bus.fail, 0);
    check("rst_locked_out", bus.locked_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_fail_cnt", bus.fail_cnt, 0);
    rst = 1'b0;
    tick();

    // Correct default key on consecutive cycles.
    enter_code(4'b1010, 0);
    open_idle_cycle();
    do_relock(1'b0);

`ifdef NIBBLE_LOCK_LOCKOUT_EN
    // Three wrong codes -> lockout, then fail count clears.
    for (int i = 0; i < 3; i++) enter_code(4'b0110, 0);
`endif

    // Key change, then old key fails and new key opens.
    enter_code(4'b1010, 1);
    do_load(4'b0111);
    do_relock(1'b0);
    enter_code(4'b1010, 0);
    enter_code(4'b0111, 0);

    // relock and load_key together: relock wins, no key load armed.
    do_relock(1'b1);
    enter_code(4'b0001, 0);
    enter_code(4'b0111, 0);
    do_relock(1'b0);

    // Asynchronous reset in the middle of an entry.
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_a", bus.a, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_b", bus.b, KEY_RESET);
    tick();
    rst = 1'b0;
    tick();
    $display("txn async reset mid-entry");
    enter_code(4'b1010, 0);
    do_relock(1'b0);

`ifndef NIBBLE_LOCK_LOCKOUT_EN
    // Eight wrong codes: no lockout, fail count saturates at 7.
    for (int i = 0; i < 8; i++) begin
      enter_code(4'b0110, 1);
      check("nolock_locked_out", bus.locked_out, 0);
    end
    enter_code(4'b1010, 0);
    do_relock(1'b0);
`endif

    // Randomized operations against the model.
    for (int t = 0; t < 60; t++) begin
      if (m_open) begin
        op = int'($urandom_range(3, 0));
        case (op)
          0: do_relock(1'b0);
          1: begin
            code = 4'($urandom);
            do_load(code);
          end
          2: do_relock(1'b1);
          default: open_idle_cycle();
        endcase
      end else begin
        code = ($urandom_range(1, 0) == 0) ? m_key : 4'($urandom);
        enter_code(code, 2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
